// File: rtl/result_collector_if.sv
// Bundles the nibble input, word output FIFO handshake and status flags of
// result_collector. Build macro RESULT_COLLECTOR_CHECKSUM_EN adds word_csum.
interface result_collector_if #(
    parameter int N       = 64,
    parameter int N_width = 4
);
    localparam int CW = $clog2(N / N_width);

    logic [N_width-1:0] nib_in;
    logic               nib_valid;
    logic [N-1:0]       word_out;
    logic               word_valid;
    logic               word_ready;
    logic [CW-1:0]      nib_count;
    logic               overflow;
    logic               frag_err;
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
    logic [N_width-1:0] word_csum;
`endif

    modport master (
        output nib_in, nib_valid, word_ready,
        input  word_out, word_valid, nib_count, overflow, frag_err
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
        , input word_csum
`endif
    );

    modport slave (
        input  nib_in, nib_valid, word_ready,
        output word_out, word_valid, nib_count, overflow, frag_err
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
        , output word_csum
`endif
    );
endinterface

// File: rtl/result_collector.sv
// Reassembles N_width-bit result nibbles (slot 0 = LSBs) into N-bit words and
// queues completed words in a DEPTH-entry FIFO. A partial word that sees
// TIMEOUT consecutive idle cycles is discarded (frag_err); a word completed
// into a full FIFO without a simultaneous pop is dropped (overflow).
// Optional build macro RESULT_COLLECTOR_CHECKSUM_EN: adds word_csum, the XOR
// of all nibbles of the head word, stored next to it in the FIFO.
//
// state   | meaning
// IDLE    | no word in progress, next nibble goes to slot 0
// COLLECT | partial word held in word_acc, idle-cycle timer running
module result_collector #(
    parameter int N       = 64,
    parameter int N_width = 4,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 8
) (
    input logic              clk,
    input logic              rst,
    result_collector_if.slave bus
);
    localparam int SLOTS = N / N_width;
    localparam int CW    = $clog2(SLOTS);
    localparam int AW    = $clog2(DEPTH);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(SLOTS - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      nib_count;
    logic [N-1:0]       word_acc;
    logic [N-1:0]       word_asm;
    logic [TW-1:0]      idle_cnt;
    logic               push_req;
    logic               timeout;
    logic               do_push;
    logic               do_pop;
    logic               full;
    logic               empty;
    logic [AW:0]        fill;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [N-1:0]       mem [DEPTH];
    logic               overflow;
    logic               frag_err;
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
    logic [N_width-1:0] csum_acc;
    logic [N_width-1:0] csum_asm;
    logic [N_width-1:0] csum_mem [DEPTH];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state: a completed word or an expired idle timer returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.nib_valid && !push_req) state_next = COLLECT;
            COLLECT: if (push_req || timeout)        state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control decode: completion of the last slot and idle timeout.
    always_comb begin
        push_req = bus.nib_valid && (nib_count == LAST);
        timeout  = (state == COLLECT) && !bus.nib_valid && (idle_cnt == '0);
    end

    // Word being built this cycle; a fresh word starts from all zeros so
    // nothing from the previous word leaks into unwritten slots.
    always_comb begin
        word_asm = (state == COLLECT) ? word_acc : '0;
        word_asm[nib_count*N_width +: N_width] = bus.nib_in;
    end

`ifdef RESULT_COLLECTOR_CHECKSUM_EN
    // Running XOR of the nibbles of the word being built.
    always_comb begin
        csum_asm = ((state == COLLECT) ? csum_acc : '0) ^ bus.nib_in;
    end
`endif

    // Slot index, partial word and idle down-counter (reloaded on each nibble).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nib_count <= '0;
            word_acc  <= '0;
            idle_cnt  <= '0;
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
            csum_acc  <= '0;
`endif
        end else if (bus.nib_valid) begin
            word_acc  <= word_asm;
            idle_cnt  <= TW'(TIMEOUT - 1);
            nib_count <= push_req ? '0 : nib_count + 1'b1;
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
            csum_acc  <= csum_asm;
`endif
        end else if (timeout) begin
            nib_count <= '0;
        end else if (state == COLLECT) begin
            idle_cnt  <= idle_cnt - 1'b1;
        end
    end

    always_comb begin
        empty   = (fill == '0);
        full    = (fill == (AW+1)'(DEPTH));
        do_pop  = !empty && bus.word_ready;
        do_push = push_req && (!full || do_pop);
    end

    // FIFO pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
            frag_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (push_req && !do_push) overflow <= 1'b1;
            if (timeout)              frag_err <= 1'b1;
        end
    end

    // FIFO storage; contents are only visible through the occupancy mask.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= word_asm;
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
            csum_mem[wr_ptr] <= csum_asm;
`endif
        end
    end

    assign bus.word_valid = !empty;
    assign bus.word_out   = empty ? '0 : mem[rd_ptr];
    assign bus.nib_count  = nib_count;
    assign bus.overflow   = overflow;
    assign bus.frag_err   = frag_err;
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
    assign bus.word_csum  = empty ? '0 : csum_mem[rd_ptr];
`endif
endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with default parameters: a vector table
// of whole words plus hand-written FIFO-full, timeout and reset sequences.
module tb_result_collector;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    result_collector_if #(.N(64), .N_width(4)) bus ();

    result_collector #(.N(64), .N_width(4), .DEPTH(2), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] data;
        int          gap;
        logic [63:0] exp_word;
        logic [3:0]  exp_csum;
    } vec_t;

    vec_t vecs [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send_nib(input logic [3:0] n);
        @(negedge clk);
        bus.nib_valid = 1'b1;
        bus.nib_in    = n;
        @(posedge clk);
        #1;
        bus.nib_valid = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w, input int gap);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) repeat (gap) @(posedge clk);
            send_nib(w[i*4 +: 4]);
        end
    endtask

    task automatic pop_word();
        @(negedge clk);
        bus.word_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.word_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vecs[0] = '{64'h0123456789ABCDEF, 0, 64'h0123456789ABCDEF, 4'h0};
        vecs[1] = '{64'hDEADBEEFCAFEF00D, 0, 64'hDEADBEEFCAFEF00D, 4'h5};
        vecs[2] = '{64'h0000000000000007, 7, 64'h0000000000000007, 4'h7};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 1, 64'hFFFFFFFFFFFFFFFF, 4'h0};
        vecs[4] = '{64'h0000000000000000, 0, 64'h0000000000000000, 4'h0};

        pass_cnt       = 0;
        total_cnt      = 0;
        rst            = 1'b0;
        bus.nib_in     = '0;
        bus.nib_valid  = 1'b0;
        bus.word_ready = 1'b0;

        #12;
        chk("rst_word_valid", 64'(bus.word_valid), 64'd0);
        chk("rst_word_out",   bus.word_out,        64'd0);
        chk("rst_nib_count",  64'(bus.nib_count),  64'd0);
        chk("rst_overflow",   64'(bus.overflow),   64'd0);
        chk("rst_frag_err",   64'(bus.frag_err),   64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Nibbles F..0 with ready held high: one-cycle valid pulse.
        bus.word_ready = 1'b1;
        for (int i = 0; i < 15; i++) send_nib(4'(15 - i));
        chk("seq_count15",  64'(bus.nib_count),  64'd15);
        chk("seq_novalid",  64'(bus.word_valid), 64'd0);
        send_nib(4'h0);
        chk("seq_valid",    64'(bus.word_valid), 64'd1);
        chk("seq_word",     bus.word_out,        64'h0123456789ABCDEF);
        chk("seq_count0",   64'(bus.nib_count),  64'd0);
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
        chk("seq_csum",     64'(bus.word_csum),  64'd0);
`endif
        @(posedge clk);
        #1;
        chk("seq_pulse_end", 64'(bus.word_valid), 64'd0);
        chk("seq_empty_out", bus.word_out,        64'd0);
        bus.word_ready = 1'b0;

        // Vector table: whole words, some with idle gaps below the timeout.
        for (int v = 0; v < 5; v++) begin
            send_word(vecs[v].data, vecs[v].gap);
            chk($sformatf("vec%0d_valid", v), 64'(bus.word_valid), 64'd1);
            chk($sformatf("vec%0d_word", v),  bus.word_out,        vecs[v].exp_word);
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
            chk($sformatf("vec%0d_csum", v),  64'(bus.word_csum),  64'(vecs[v].exp_csum));
`endif
            pop_word();
            chk($sformatf("vec%0d_popped", v), 64'(bus.word_valid), 64'd0);
        end
        chk("vec_frag_err", 64'(bus.frag_err), 64'd0);
        chk("vec_overflow", 64'(bus.overflow), 64'd0);

        // Three words into a two-entry FIFO with no pops: third is dropped.
        send_word({16{4'h1}}, 0);
        send_word({16{4'h2}}, 0);
        chk("ovf_before", 64'(bus.overflow), 64'd0);
        send_word({16{4'h3}}, 0);
        chk("ovf_set",   64'(bus.overflow),  64'd1);
        chk("ovf_head1", bus.word_out,       {16{4'h1}});
        pop_word();
        chk("ovf_head2", bus.word_out,       {16{4'h2}});
        pop_word();
        chk("ovf_empty", 64'(bus.word_valid), 64'd0);
        chk("ovf_zero",  bus.word_out,        64'd0);
        chk("ovf_sticky", 64'(bus.overflow),  64'd1);

        // Timeout: 7 idle cycles keep the fragment, the 8th discards it.
        do_reset();
        for (int i = 0; i < 5; i++) send_nib(4'h7);
        repeat (7) @(posedge clk);
        #1;
        chk("to_7_frag",  64'(bus.frag_err),  64'd0);
        chk("to_7_count", 64'(bus.nib_count), 64'd5);
        @(posedge clk);
        #1;
        chk("to_8_frag",  64'(bus.frag_err),  64'd1);
        chk("to_8_count", 64'(bus.nib_count), 64'd0);
        send_word({16{4'hA}}, 0);
        chk("to_word",     bus.word_out,        64'hAAAAAAAAAAAAAAAA);
        chk("to_valid",    64'(bus.word_valid), 64'd1);
        chk("to_frag_hold", 64'(bus.frag_err),  64'd1);

        // Full FIFO with a pop on the completing edge: no overflow.
        do_reset();
        send_word({16{4'h1}}, 0);
        send_word({16{4'h2}}, 0);
        for (int i = 0; i < 15; i++) send_nib(4'h3);
        @(negedge clk);
        bus.nib_valid  = 1'b1;
        bus.nib_in     = 4'h3;
        bus.word_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.nib_valid  = 1'b0;
        bus.word_ready = 1'b0;
        chk("pp_overflow", 64'(bus.overflow), 64'd0);
        chk("pp_head",     bus.word_out,      {16{4'h2}});
        pop_word();
        chk("pp_tail",     bus.word_out,      {16{4'h3}});
        pop_word();
        chk("pp_empty",    64'(bus.word_valid), 64'd0);

        // Reset mid-word with a queued word discards everything.
        send_word({16{4'h9}}, 0);
        for (int i = 0; i < 10; i++) send_nib(4'hC);
        chk("mr_count10", 64'(bus.nib_count), 64'd10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_rst_valid", 64'(bus.word_valid), 64'd0);
        chk("mr_rst_word",  bus.word_out,        64'd0);
        chk("mr_rst_count", 64'(bus.nib_count),  64'd0);
        @(negedge clk);
        rst = 1'b1;
        send_word({16{4'h5}}, 0);
        chk("mr_word",     bus.word_out,        64'h5555555555555555);
        chk("mr_valid",    64'(bus.word_valid), 64'd1);
        chk("mr_overflow", 64'(bus.overflow),   64'd0);
        chk("mr_frag_err", 64'(bus.frag_err),   64'd0);
        pop_word();
        chk("mr_empty",    64'(bus.word_valid), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
